// File: rtl/com_in_state_decoder.sv
// Serial state-announcement receiver: synchronizes the one-wire line, decodes start/data/stop frames
// and publishes the announced state code. Define ANNOUNCE_PARITY_EN to expect an even-parity bit.
module com_in_state_decoder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               state_announcement,
    output logic [STATE_W-1:0] state_out,
    output logic               state_valid,
    output logic               frame_error,
    output logic               parity_error,
    output logic               busy
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W   = $clog2(STATE_W + 1);

    localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] TIMER_FULL = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STATE_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef ANNOUNCE_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef ANNOUNCE_PARITY_EN
    function automatic logic even_parity_ok(input logic [STATE_W-1:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction
`endif

    logic               sync1_r;
    logic               sync2_r;
    logic               line_s;
    state_t             state_r;
    state_t             state_n_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_n_s;
    logic [CNT_W-1:0]   bitcnt_r;
    logic [CNT_W-1:0]   bitcnt_n_s;
    logic [STATE_W-1:0] shreg_r;
    logic [STATE_W-1:0] shreg_n_s;
    logic               armed_r;
    logic               armed_n_s;
    logic               done_r;
    logic               done_n_s;
    logic               stop_r;
    logic               stop_n_s;
    logic               parity_ok_s;
    logic               accept_s;
`ifdef ANNOUNCE_PARITY_EN
    logic               par_r;
    logic               par_n_s;
    logic               parity_error_r;
`endif

    // Two-flop synchronizer; resets high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= state_announcement;
            sync2_r <= sync1_r;
        end
    end

    assign line_s = sync2_r;

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            timer_r  <= TIMER_ZERO;
            bitcnt_r <= CNT_ZERO;
            shreg_r  <= {STATE_W{1'b0}};
            armed_r  <= 1'b0;
            done_r   <= 1'b0;
            stop_r   <= 1'b0;
`ifdef ANNOUNCE_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_n_s;
            timer_r  <= timer_n_s;
            bitcnt_r <= bitcnt_n_s;
            shreg_r  <= shreg_n_s;
            armed_r  <= armed_n_s;
            done_r   <= done_n_s;
            stop_r   <= stop_n_s;
`ifdef ANNOUNCE_PARITY_EN
            par_r    <= par_n_s;
`endif
        end
    end

    // Frame sequencing: all samples are taken mid-bit, timed from the middle of the start bit.
    always_comb begin
        state_n_s  = state_r;
        timer_n_s  = timer_r;
        bitcnt_n_s = bitcnt_r;
        shreg_n_s  = shreg_r;
        armed_n_s  = armed_r;
        done_n_s   = 1'b0;
        stop_n_s   = stop_r;
`ifdef ANNOUNCE_PARITY_EN
        par_n_s    = par_r;
`endif
        case (state_r)
            IDLE: begin
                timer_n_s  = TIMER_ZERO;
                bitcnt_n_s = CNT_ZERO;
                // A start edge only counts after the line has been seen idle, so a stuck-low line is ignored.
                if (line_s) begin
                    armed_n_s = 1'b1;
                end else if (armed_r) begin
                    armed_n_s = 1'b0;
                    state_n_s = START;
                end else begin
                    armed_n_s = 1'b0;
                end
            end
            START: begin
                if (timer_r == TIMER_HALF) begin
                    timer_n_s = TIMER_ZERO;
                    if (line_s) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DATA;
                    end
                end else begin
                    timer_n_s = timer_r + TIMER_ONE;
                end
            end
            DATA: begin
                if (timer_r == TIMER_FULL) begin
                    timer_n_s                 = TIMER_ZERO;
                    shreg_n_s                 = shreg_r >> 1;
                    shreg_n_s[STATE_W-1]      = line_s;
                    if (bitcnt_r == CNT_LAST) begin
                        bitcnt_n_s = CNT_ZERO;
`ifdef ANNOUNCE_PARITY_EN
                        state_n_s  = PARITY;
`else
                        state_n_s  = STOP;
`endif
                    end else begin
                        bitcnt_n_s = bitcnt_r + CNT_ONE;
                    end
                end else begin
                    timer_n_s = timer_r + TIMER_ONE;
                end
            end
`ifdef ANNOUNCE_PARITY_EN
            PARITY: begin
                if (timer_r == TIMER_FULL) begin
                    timer_n_s = TIMER_ZERO;
                    par_n_s   = line_s;
                    state_n_s = STOP;
                end else begin
                    timer_n_s = timer_r + TIMER_ONE;
                end
            end
`endif
            STOP: begin
                if (timer_r == TIMER_FULL) begin
                    timer_n_s = TIMER_ZERO;
                    stop_n_s  = line_s;
                    done_n_s  = 1'b1;
                    state_n_s = IDLE;
                end else begin
                    timer_n_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_n_s  = IDLE;
                timer_n_s  = TIMER_ZERO;
                bitcnt_n_s = CNT_ZERO;
                armed_n_s  = 1'b0;
            end
        endcase
    end

`ifdef ANNOUNCE_PARITY_EN
    assign parity_ok_s = even_parity_ok(shreg_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // A bad stop bit takes precedence over a parity mismatch.
    assign accept_s = done_r & stop_r & parity_ok_s;

    // Registered result outputs, one cycle after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out   <= {STATE_W{1'b0}};
            state_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_valid <= accept_s;
            frame_error <= done_r & ~stop_r;
            busy        <= (state_n_s != IDLE);
            if (accept_s) begin
                state_out <= shreg_r;
            end else begin
                state_out <= state_out;
            end
        end
    end

`ifdef ANNOUNCE_PARITY_EN
    // Parity mismatch pulse, only reported for frames with a good stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_error_r <= 1'b0;
        end else begin
            parity_error_r <= done_r & stop_r & ~parity_ok_s;
        end
    end

    assign parity_error = parity_error_r;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_com_in_state_decoder.sv
// Self-checking bench for com_in_state_decoder: directed scenarios plus randomized frames
// compared against a frame-level reference model of expected result pulses and their timing.
module tb_com_in_state_decoder;

    localparam int CLKS = 16;
    localparam int W    = 4;
`ifdef ANNOUNCE_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Edges from the first clock edge that sees the falling start edge to the result pulse.
    localparam int LAT = CLKS / 2 + (W + 1 + PB) * CLKS + 3;

    typedef struct {
        int           cyc;
        int           kind;   // 0 valid, 1 frame error, 2 parity error
        logic [W-1:0] val;
    } ev_t;

    logic         clk;
    logic         rst;
    logic         line;
    logic [W-1:0] state_out;
    logic         state_valid;
    logic         frame_error;
    logic         parity_error;
    logic         busy;

    int           cyc;
    int           checks;
    int           errors;
    int           overlap_cnt;
    int           busy_cnt;
    logic [W-1:0] model_state;
    ev_t          obs_q[$];
    ev_t          exp_q[$];

    com_in_state_decoder #(.CLKS_PER_BIT(CLKS), .STATE_W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .state_announcement(line),
        .state_out         (state_out),
        .state_valid       (state_valid),
        .frame_error       (frame_error),
        .parity_error      (parity_error),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every high cycle of each result pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if ((int'(state_valid) + int'(frame_error) + int'(parity_error)) > 1) overlap_cnt++;
        if (state_valid === 1'b1) obs_q.push_back('{cyc, 0, state_out});
        if (frame_error === 1'b1) obs_q.push_back('{cyc, 1, state_out});
        if (parity_error === 1'b1) obs_q.push_back('{cyc, 2, state_out});
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic drive_bit(input logic b);
        line = b;
        repeat (CLKS) @(negedge clk);
    endtask

    // Serialize one frame and predict its single result pulse from the frame contents alone.
    task automatic send_frame(input logic [W-1:0] d, input logic stopb, input logic parb);
        int fall;
        int k;
        fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
`ifdef ANNOUNCE_PARITY_EN
        drive_bit(parb);
`endif
        drive_bit(stopb);
        if (!stopb) k = 1;
        else if (PB == 1 && ((^d) != parb)) k = 2;
        else k = 0;
        if (k == 0) model_state = d;
        exp_q.push_back('{fall + 1 + LAT, k, model_state});
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state_out !== 4'h0) begin errors++; $display("FAIL reset_state_out: got %h expected 0", state_out); end
        checks++; if (state_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", state_valid); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        model_state = 4'h0;
        idle(5);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_frame;
        send_frame(4'hA, 1'b1, ^(4'hA));
        idle(20);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d events expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].kind !== 0 || obs_q[0].val !== 4'hA) begin
                errors++;
                $display("FAIL single_event: got cyc=%0d kind=%0d val=%h expected cyc=%0d kind=0 val=a",
                         obs_q[0].cyc, obs_q[0].kind, obs_q[0].val, exp_q[0].cyc);
            end
        end
        checks++; if (state_out !== 4'hA) begin errors++; $display("FAIL single_state_out: got %h expected a", state_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch;
        int b0;
        b0 = busy_cnt;
        line = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        checks++; if (busy_cnt - b0 !== CLKS / 2) begin errors++; $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt - b0, CLKS / 2); end
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL glitch_no_pulse: got %0d events expected 0", obs_q.size()); end
        checks++; if (state_out !== model_state) begin errors++; $display("FAIL glitch_state_out: got %h expected %h", state_out, model_state); end
        obs_q.delete();
    endtask

    task automatic test_stuck_low;
        int b0;
        send_frame(4'h5, 1'b0, ^(4'h5));
        b0 = busy_cnt;
        repeat (200) @(negedge clk);
        checks++; if (busy_cnt !== b0) begin errors++; $display("FAIL stuck_busy: got %0d busy cycles expected 0", busy_cnt - b0); end
        checks++; if (state_out !== model_state) begin errors++; $display("FAIL stuck_state_out: got %h expected %h", state_out, model_state); end
        idle(40);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL stuck_count: got %0d events expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].kind !== 1) begin
                errors++;
                $display("FAIL stuck_event: got cyc=%0d kind=%0d expected cyc=%0d kind=1", obs_q[0].cyc, obs_q[0].kind, exp_q[0].cyc);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(4'h3, 1'b1, ^(4'h3));
        send_frame(4'hC, 1'b1, ^(4'hC));
        idle(20);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d events expected 2", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
                errors++;
                $display("FAIL b2b_event%0d: got cyc=%0d kind=%0d val=%h expected cyc=%0d kind=%0d val=%h", i,
                         obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
        checks++; if (state_out !== 4'hC) begin errors++; $display("FAIL b2b_state_out: got %h expected c", state_out); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        line = 1'b1;
        repeat (CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (state_out !== 4'h0 || state_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got out=%h v=%b fe=%b busy=%b expected all 0", state_out, state_valid, frame_error, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_state = 4'h0;
        idle(3 * CLKS);
        send_frame(4'h6, 1'b1, ^(4'h6));
        idle(20);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d events expected 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].kind !== 0 || obs_q[0].val !== 4'h6) begin
                errors++;
                $display("FAIL midrst_event: got cyc=%0d kind=%0d val=%h expected cyc=%0d kind=0 val=6",
                         obs_q[0].cyc, obs_q[0].kind, obs_q[0].val, exp_q[0].cyc);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef ANNOUNCE_PARITY_EN
    task automatic test_parity;
        logic [W-1:0] prior;
        prior = model_state;
        send_frame(4'h7, 1'b1, 1'b0);
        idle(20);
        checks++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0].kind !== 2)) begin
            errors++; $display("FAIL parity_bad_pulse: got %0d events expected one parity error", obs_q.size());
        end
        checks++; if (state_out !== prior) begin errors++; $display("FAIL parity_bad_hold: got %h expected %h", state_out, prior); end
        obs_q.delete();
        exp_q.delete();
        send_frame(4'h7, 1'b1, 1'b1);
        idle(20);
        checks++; if (obs_q.size() !== 1 || (obs_q.size() > 0 && obs_q[0].kind !== 0)) begin
            errors++; $display("FAIL parity_good_pulse: got %0d events expected one valid", obs_q.size());
        end
        checks++; if (state_out !== 4'h7) begin errors++; $display("FAIL parity_good_state: got %h expected 7", state_out); end
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_random;
        logic [W-1:0] d;
        logic         stopb;
        logic         parb;
        int           gap;
        for (int n = 0; n < 16; n++) begin
            d     = W'($urandom_range(0, 15));
            stopb = ($urandom_range(0, 5) != 0);
            parb  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            send_frame(d, stopb, parb);
            if (!stopb) gap = CLKS + int'($urandom_range(0, 20));
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = int'($urandom_range(1, 40));
            idle(gap);
        end
        idle(30);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d events expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
                errors++;
                $display("FAIL rand_event%0d: got cyc=%0d kind=%0d val=%h expected cyc=%0d kind=%0d val=%h", i,
                         obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
            end
        end
        checks++; if (state_out !== model_state) begin errors++; $display("FAIL rand_final_state: got %h expected %h", state_out, model_state); end
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", overlap_cnt); end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        overlap_cnt = 0;
        busy_cnt    = 0;
        model_state = 4'h0;
        rst         = 1'b1;
        line        = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_glitch();
        test_stuck_low();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef ANNOUNCE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
